// File: rtl/uart_core.sv
// Full-duplex UART: 16x oversampled receiver, valid/ready transmitter, receive error flags.
// Define UART_PARITY_EN to add a parity bit to each frame (parity_odd / rx_parity_err ports).
//
// state      | meaning
// IDLE       | line idle (TX: ready for a byte; RX: watching for a falling edge)
// START      | start bit (TX drives 0; RX confirms low at the bit midpoint)
// DATA       | payload bits, LSB first
// PARITY     | parity bit (only with UART_PARITY_EN)
// STOP       | stop bit (TX drives 1; RX samples it, then returns to IDLE)
module uart_core #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK50M,
    input  logic                 RST,
    input  logic                 UART_RXD,
    output logic                 UART_TXD,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 rx_ack,
`ifdef UART_PARITY_EN
    input  logic                 parity_odd,
    output logic                 rx_parity_err,
`endif
    output logic                 tx_busy
);

    localparam int DIV      = CLK_HZ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV;
    localparam int DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW       = $clog2(BIT_CLKS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(BIT_CLKS - 1);
    localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    // ---------------- oversampling tick ----------------
    logic [DW-1:0] div_cnt;
    logic          tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK50M) begin
        if (RST || tick) div_cnt <= '0;
        else             div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- transmitter ----------------
    // Bit cells are timed from the moment a byte is accepted, so every bit is exactly 16*DIV clocks.
    tx_state_t            tx_state, tx_state_nxt;
    logic [TW-1:0]        tx_timer;
    logic [3:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shreg;
    logic                 txd_q, txd_nxt;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end = (tx_timer == '0);
    assign tx_ready   = (tx_state == TX_IDLE);
    assign tx_busy    = (tx_state != TX_IDLE);
    assign UART_TXD   = txd_q;

    always_comb begin
        tx_state_nxt = tx_state;
        txd_nxt      = txd_q;
        case (tx_state)
            TX_IDLE: begin
                txd_nxt = 1'b1;
                if (tx_valid) begin
                    tx_state_nxt = TX_START;
                    txd_nxt      = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_DATA;
                    txd_nxt      = tx_shreg[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                        tx_state_nxt = TX_PARITY;
                        txd_nxt      = tx_par;
`else
                        tx_state_nxt = TX_STOP;
                        txd_nxt      = 1'b1;
`endif
                    end else begin
                        txd_nxt = tx_shreg[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_STOP;
                    txd_nxt      = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_state_nxt = TX_IDLE;
                    txd_nxt      = 1'b1;
                end
            end
            default: begin
                tx_state_nxt = TX_IDLE;
                txd_nxt      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            tx_state <= TX_IDLE;
            txd_q    <= 1'b1;
            tx_timer <= '0;
            tx_idx   <= '0;
            tx_shreg <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_nxt;
            txd_q    <= txd_nxt;
            if (tx_state == TX_IDLE) begin
                tx_timer <= BIT_LAST;
                tx_idx   <= '0;
                if (tx_valid) begin
                    tx_shreg <= tx_data;
`ifdef UART_PARITY_EN
                    tx_par   <= (^tx_data) ^ parity_odd;
`endif
                end
            end else if (tx_bit_end) begin
                tx_timer <= BIT_LAST;
                if (tx_state == TX_DATA) begin
                    tx_shreg <= tx_shreg >> 1;
                    tx_idx   <= tx_idx + 1'b1;
                end
            end else begin
                tx_timer <= tx_timer - 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_meta, rx_sync, rx_prev;
    rx_state_t            rx_state, rx_state_nxt;
    logic [3:0]           rx_tcnt;
    logic [3:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shreg;
    logic                 rx_done;
    logic                 rx_unread;
    logic                 start_mid, bit_mid;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad;
`endif

    assign start_mid = tick && (rx_tcnt == 4'd7);
    assign bit_mid   = tick && (rx_tcnt == 4'd15);

    always_comb begin
        rx_state_nxt = rx_state;
        rx_done      = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
            RX_START: if (start_mid) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (bit_mid && rx_idx == IDX_LAST) begin
`ifdef UART_PARITY_EN
                    rx_state_nxt = RX_PARITY;
`else
                    rx_state_nxt = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (bit_mid) rx_state_nxt = RX_STOP;
`endif
            RX_STOP: begin
                if (bit_mid) begin
                    rx_state_nxt = RX_IDLE;
                    rx_done      = 1'b1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK50M) begin
        if (RST) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_prev      <= 1'b1;
            rx_state     <= RX_IDLE;
            rx_tcnt      <= '0;
            rx_idx       <= '0;
            rx_shreg     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_unread    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad    <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_meta  <= UART_RXD;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_nxt;

            // Counter wraps 15->0 on its own, giving one sample every 16 ticks after the start midpoint.
            if (rx_state == RX_IDLE || (rx_state == RX_START && start_mid)) rx_tcnt <= '0;
            else if (tick)                                                 rx_tcnt <= rx_tcnt + 1'b1;

            if (rx_state == RX_IDLE) begin
                rx_idx <= '0;
            end else if (rx_state == RX_DATA && bit_mid) begin
                rx_shreg <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
                rx_idx   <= rx_idx + 1'b1;
            end

`ifdef UART_PARITY_EN
            if (rx_state == RX_PARITY && bit_mid)
                rx_par_bad <= rx_sync ^ (^rx_shreg) ^ parity_odd;
            rx_parity_err <= rx_done && rx_par_bad;
`endif

            rx_valid     <= rx_done;
            rx_frame_err <= rx_done && !rx_sync;
            if (rx_done) rx_data <= rx_shreg;

            // An ack coinciding with completion retires the old frame; the new one stays unread.
            if (rx_done) begin
                rx_unread <= 1'b1;
                if (rx_ack)         rx_overrun <= 1'b0;
                else if (rx_unread) rx_overrun <= 1'b1;
            end else if (rx_ack) begin
                rx_unread  <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed self-checking bench for uart_core at default parameters (50 MHz, 115200 baud, 8 bits).
module tb_uart_core;

    localparam int BIT = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic       txd;
    logic       rxd_line;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_ack;
    logic       tx_busy;

    logic lb_en   = 1'b0;
    logic drv_rxd = 1'b1;
    logic auto_ack = 1'b0, auto_ack_q = 1'b0, man_ack = 1'b0;

    assign rxd_line = lb_en ? txd : drv_rxd;
    assign rx_ack   = auto_ack_q | man_ack;

    always #10 clk = ~clk;

    uart_core dut (
        .CLK50M      (clk),
        .RST         (rst),
        .UART_RXD    (rxd_line),
        .UART_TXD    (txd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_ack      (rx_ack),
        .tx_busy     (tx_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    int         rx_cnt = 0;
    logic [7:0] log_data [0:31];
    logic       log_ferr [0:31];

    always @(negedge clk) begin
        if (rx_valid) begin
            log_data[rx_cnt[4:0]] = rx_data;
            log_ferr[rx_cnt[4:0]] = rx_frame_err;
            rx_cnt++;
        end
        auto_ack_q = auto_ack && rx_valid;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_send(input logic [7:0] b, output int acc);
        int n = 0;
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        acc      = cyc;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            drv_rxd = f[k];
            wait_cycles(BIT);
        end
        drv_rxd = 1'b1;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [9:0] frame;
        logic [7:0] lb_bytes [0:2];
        int a0, a1, a2, base, n;

        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        wait_cycles(3);
        check_val("rst_txd",     32'(txd), 32'd1);
        check_val("rst_ready",   32'(tx_ready), 32'd1);
        check_val("rst_busy",    32'(tx_busy), 32'd0);
        check_val("rst_rxvalid", 32'(rx_valid), 32'd0);
        check_val("rst_overrun", 32'(rx_overrun), 32'd0);
        check_val("rst_rxdata",  32'(rx_data), 32'd0);
        rst = 1'b0;
        wait_cycles(5);

        // Single 0x5A frame: check first and last clock of every bit cell and the ready return.
        frame = {1'b1, 8'h5A, 1'b0};
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check_val("tx_busy_start", 32'(tx_busy), 32'd1);
        for (int c = 0; c <= 10 * BIT; c++) begin
            if (c < 10 * BIT && ((c % BIT) == 0 || (c % BIT) == BIT - 1))
                check_val("tx_bit", 32'(txd), 32'(frame[c / BIT]));
            if (c == 10 * BIT - 1) check_val("tx_ready_last", 32'(tx_ready), 32'd0);
            if (c == 10 * BIT)     check_val("tx_ready_back", 32'(tx_ready), 32'd1);
            @(negedge clk);
        end

        // Loopback, back-to-back frames.
        auto_ack    = 1'b1;
        lb_en       = 1'b1;
        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'hA5;
        base = rx_cnt;
        tx_send(lb_bytes[0], a0);
        tx_send(lb_bytes[1], a1);
        tx_send(lb_bytes[2], a2);
        check_val("b2b_gap1", 32'(a1 - a0), 32'(10 * BIT + 1));
        check_val("b2b_gap2", 32'(a2 - a1), 32'(10 * BIT + 1));
        n = 0;
        while (rx_cnt < base + 3 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check_val("lb_count", 32'(rx_cnt - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("lb_data", 32'(log_data[base + i]), 32'(lb_bytes[i]));
            check_val("lb_ferr", 32'(log_ferr[base + i]), 32'd0);
        end
        check_val("lb_overrun", 32'(rx_overrun), 32'd0);
        n = 0;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        lb_en = 1'b0;
        wait_cycles(50);

        // Bad stop bit, glitch rejection, then a clean bench-driven frame.
        base = rx_cnt;
        send_frame(8'h3C, 1'b0);
        wait_cycles(500);
        check_val("ferr_count", 32'(rx_cnt - base), 32'd1);
        check_val("ferr_data",  32'(log_data[base]), 32'h3C);
        check_val("ferr_flag",  32'(log_ferr[base]), 32'd1);
        base = rx_cnt;
        drv_rxd = 1'b0;
        wait_cycles(100);
        drv_rxd = 1'b1;
        wait_cycles(1000);
        check_val("glitch_count", 32'(rx_cnt - base), 32'd0);
        send_frame(8'hC3, 1'b1);
        wait_cycles(500);
        check_val("good_count", 32'(rx_cnt - base), 32'd1);
        check_val("good_data",  32'(log_data[base]), 32'hC3);
        check_val("good_ferr",  32'(log_ferr[base]), 32'd0);

        // Overrun: two frames without ack, then ack clears it.
        auto_ack = 1'b0;
        wait_cycles(10);
        send_frame(8'h11, 1'b1);
        wait_cycles(500);
        check_val("ovr_first",  32'(rx_overrun), 32'd0);
        check_val("ovr_data1",  32'(rx_data), 32'h11);
        send_frame(8'h22, 1'b1);
        wait_cycles(500);
        check_val("ovr_set",    32'(rx_overrun), 32'd1);
        check_val("ovr_data2",  32'(rx_data), 32'h22);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        @(negedge clk);
        check_val("ovr_clear",  32'(rx_overrun), 32'd0);
        send_frame(8'h33, 1'b1);
        wait_cycles(500);
        check_val("ovr_after_ack", 32'(rx_overrun), 32'd0);
        check_val("ovr_data3",     32'(rx_data), 32'h33);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;

        // Reset in the middle of a TX frame and an RX frame.
        auto_ack = 1'b1;
        base = rx_cnt;
        tx_send(8'h00, a0);
        drv_rxd = 1'b0;
        wait_cycles(600);
        check_val("mid_txd_low", 32'(txd), 32'd0);
        rst     = 1'b1;
        drv_rxd = 1'b1;
        @(negedge clk);
        check_val("mid_rst_txd",   32'(txd), 32'd1);
        check_val("mid_rst_ready", 32'(tx_ready), 32'd1);
        check_val("mid_rst_rxd",   32'(rx_data), 32'd0);
        rst = 1'b0;
        wait_cycles(5000);
        check_val("mid_rst_norx",  32'(rx_cnt - base), 32'd0);
        check_val("mid_rst_busy",  32'(tx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
